pito_uart_arb: RTL and testbench

PITO_UART_ARB -- requirements
Module: pito_uart_arb

---
 rtl/pito_uart_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_pito_uart_arb.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pito_uart_arb.sv
// rtl/pito_uart_arb.sv - round-robin arbiter sharing one byte-wide UART transmitter
//
// Purpose:
//   Grants one of NUM_REQ byte-stream requesters exclusive use of a UART
//   transmitter. A grant lasts until the requester ends its message
//   (req_last), sends MAX_BURST bytes, or leaves req_valid low for IDLE_TO
//   cycles. Each accepted byte is issued as a one-cycle uart_wr strobe, and
//   the arbiter then waits for uart_busy to rise and fall before accepting
//   the next byte. If uart_busy never rises within HI_TO cycles, the sticky
//   hi_err flag is set and the byte is treated as sent.
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   req_valid     [NUM_REQ]    per-requester byte available
//   req_data      [8*NUM_REQ]  byte i at [8i+7:8i]
//   req_last      [NUM_REQ]    byte ends the message
//   req_ready     [NUM_REQ]    byte taken when valid & ready
//   uart_wr       one-cycle send strobe
//   uart_tx_data  byte to the UART (holds the last byte sent)
//   uart_busy     UART transmitter busy
//   grant_valid   a requester holds the UART
//   grant_id      index of the holder
//   hi_err        sticky: uart_busy failed to rise after a send
module pito_uart_arb #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64,
  parameter int IDLE_TO   = 16,
  parameter int HI_TO     = 4,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_wr,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_busy,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic                 hi_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  state_t         r_state,     w_state_nxt;
  logic [IDW-1:0] r_rr_ptr,    w_rr_ptr_nxt;
  logic [IDW-1:0] r_grant_id,  w_grant_id_nxt;
  logic [7:0]     r_burst_cnt, w_burst_cnt_nxt;
  logic [7:0]     r_idle_cnt,  w_idle_cnt_nxt;
  logic [3:0]     r_hi_cnt,    w_hi_cnt_nxt;
  logic [7:0]     r_tx_data,   w_tx_data_nxt;
  logic           r_last,      w_last_nxt;
  logic           r_uart_wr,   w_uart_wr_nxt;
  logic           r_hi_err,    w_hi_err_nxt;

  logic           w_arb_found;
  logic [IDW-1:0] w_arb_id;
  logic           w_sel_valid;
  logic           w_sel_last;
  logic [7:0]     w_sel_data;
  logic [7:0]     w_burst_inc;
  logic [IDW-1:0] w_ptr_after;
  logic           w_done;
  logic           w_release;

  // First valid requester at or above rr_ptr, wrapping. Scanning k from the
  // top down lets the smallest offset overwrite the others.
  always_comb begin : p_arb
    int idx;
    idx         = 0;
    w_arb_found = 1'b0;
    w_arb_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        w_arb_found = 1'b1;
        w_arb_id    = IDW'(idx);
      end
    end
  end

  // Inputs of the current grant holder.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == r_grant_id) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == ST_LOCKED && !uart_busy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IDW'(i) == r_grant_id) req_ready[i] = 1'b1;
      end
    end
  end

  assign w_burst_inc = (r_burst_cnt == 8'hFF) ? r_burst_cnt : r_burst_cnt + 8'd1;
  assign w_ptr_after = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_id_nxt  = r_grant_id;
    w_burst_cnt_nxt = r_burst_cnt;
    w_idle_cnt_nxt  = r_idle_cnt;
    w_hi_cnt_nxt    = r_hi_cnt;
    w_tx_data_nxt   = r_tx_data;
    w_last_nxt      = r_last;
    w_uart_wr_nxt   = 1'b0;
    w_hi_err_nxt    = r_hi_err;
    w_done          = 1'b0;
    w_release       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_found) begin
          w_state_nxt     = ST_LOCKED;
          w_grant_id_nxt  = w_arb_id;
          w_burst_cnt_nxt = '0;
          w_idle_cnt_nxt  = '0;
        end
      end

      ST_LOCKED: begin
        // A busy UART freezes the grant entirely: no accept, no idle timing.
        if (!uart_busy) begin
          if (w_sel_valid) begin
            w_tx_data_nxt  = w_sel_data;
            w_last_nxt     = w_sel_last;
            w_uart_wr_nxt  = 1'b1;
            w_idle_cnt_nxt = '0;
            w_hi_cnt_nxt   = '0;
            w_state_nxt    = ST_WAIT_HI;
          end else if (r_idle_cnt + 8'd1 >= 8'(IDLE_TO)) begin
            w_release = 1'b1;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 8'd1;
          end
        end
      end

      ST_WAIT_HI: begin
        // The strobe cycle itself is not part of the HI_TO window.
        if (uart_busy) begin
          w_state_nxt = ST_WAIT_LO;
        end else if (!r_uart_wr) begin
          if (r_hi_cnt + 4'd1 >= 4'(HI_TO)) begin
            w_hi_err_nxt = 1'b1;
            w_done       = 1'b1;
          end else begin
            w_hi_cnt_nxt = r_hi_cnt + 4'd1;
          end
        end
      end

      ST_WAIT_LO: begin
        if (!uart_busy) w_done = 1'b1;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_done) begin
      w_burst_cnt_nxt = w_burst_inc;
      if (r_last || (w_burst_inc >= 8'(MAX_BURST))) begin
        w_release = 1'b1;
      end else begin
        w_state_nxt = ST_LOCKED;
      end
    end

    // The released holder becomes lowest priority for the next search.
    if (w_release) begin
      w_state_nxt  = ST_IDLE;
      w_rr_ptr_nxt = w_ptr_after;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      r_hi_cnt    <= '0;
      r_tx_data   <= '0;
      r_last      <= 1'b0;
      r_uart_wr   <= 1'b0;
      r_hi_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_hi_cnt    <= w_hi_cnt_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_last      <= w_last_nxt;
      r_uart_wr   <= w_uart_wr_nxt;
      r_hi_err    <= w_hi_err_nxt;
    end
  end

  assign uart_wr      = r_uart_wr;
  assign uart_tx_data = r_tx_data;
  assign grant_valid  = (r_state != ST_IDLE);
  assign grant_id     = r_grant_id;
  assign hi_err       = r_hi_err;

endmodule

// File: tb/tb_pito_uart_arb.sv
// tb/tb_pito_uart_arb.sv - self-checking bench for pito_uart_arb
module tb_pito_uart_arb;
  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int IT  = 16;
  localparam int HT  = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              uart_wr;
  logic [7:0]        uart_tx_data;
  logic              uart_busy;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;
  logic              hi_err;

  pito_uart_arb #(.NUM_REQ(NR), .MAX_BURST(MB), .IDLE_TO(IT), .HI_TO(HT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
    .grant_valid(grant_valid), .grant_id(grant_id), .hi_err(hi_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-requester pending bytes {last, data}, and the reference model state.
  logic [8:0]       q  [NR][$];
  logic [8:0]       mq [NR][$];
  logic [IDW+7:0]   exp_q[$];
  logic [IDW+7:0]   got_q[$];
  int               gap[NR];
  int               m_ptr;
  bit               m_hi;

  // Message-level round robin: serve the first non-empty queue from m_ptr,
  // up to the end of its message or MB bytes, or until it runs dry.
  function automatic void build_expected();
    int g;
    int cnt;
    int idx;
    logic [8:0] e;
    exp_q.delete();
    for (int i = 0; i < NR; i++) mq[i] = q[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g < 0) break;
      cnt = 0;
      while (mq[g].size() > 0) begin
        e = mq[g].pop_front();
        exp_q.push_back({IDW'(g), e[7:0]});
        cnt++;
        if (e[8] || cnt == MB) break;
      end
      m_ptr = (g + 1) % NR;
    end
  endfunction

  task automatic drive_reqs();
    logic [8:0] e;
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() > 0) begin
        e = q[i][0];
        req_data[8*i +: 8] = e[7:0];
        req_last[i]        = e[8];
        req_valid[i]       = !(gap[i] > 0 && grant_valid && grant_id == IDW'(i));
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    uart_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
    m_hi  = 1'b0;
  endtask

  // Plays the queued traffic against a UART busy model and checks strobe
  // timing, ready legality, hi_err, and the final byte order.
  task automatic run_traffic(input bit tied, input int dmin, input int dmax,
                             input int lmin, input int lmax, input bit gaps);
    int b_delay;
    int b_len;
    int first_wr;
    bit pend_wr;
    bit done;
    bit empty;
    logic [7:0]    pend_byte;
    logic [NR-1:0] acc;
    logic [NR-1:0] mask;
    b_delay = -1; b_len = 0; first_wr = -1; pend_wr = 0; done = 0;
    pend_byte = '0;
    build_expected();
    got_q.delete();
    for (int i = 0; i < NR; i++) gap[i] = 0;
    uart_busy = 1'b0;
    @(posedge clk); #1;
    drive_reqs();
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (uart_wr !== pend_wr) begin
        n_err++;
        $display("FAIL wr_timing cyc=%0d got=%b exp=%b", cyc, uart_wr, pend_wr);
      end
      if (pend_wr) begin
        n_vec++;
        if (uart_tx_data !== pend_byte) begin
          n_err++;
          $display("FAIL tx_data cyc=%0d got=%h exp=%h", cyc, uart_tx_data, pend_byte);
        end
      end
      if (uart_wr) begin
        got_q.push_back({grant_id, uart_tx_data});
        if (first_wr < 0) first_wr = cyc;
      end
      if (tied && first_wr >= 0 && cyc >= first_wr + HT + 1) m_hi = 1'b1;
      n_vec++;
      if (hi_err !== m_hi) begin
        n_err++;
        $display("FAIL hi_err cyc=%0d got=%b exp=%b", cyc, hi_err, m_hi);
      end
      if (uart_busy) begin
        b_len--;
        if (b_len == 0) uart_busy = 1'b0;
      end
      if (uart_wr && !tied) b_delay = $urandom_range(dmax, dmin);
      if (b_delay == 0) begin
        uart_busy = 1'b1;
        b_len     = $urandom_range(lmax, lmin);
        b_delay   = -1;
      end else if (b_delay > 0) begin
        b_delay--;
      end
      #1;
      mask = (grant_valid && !uart_busy) ? (NR'(1) << grant_id) : '0;
      n_vec++;
      if ((req_ready & ~mask) !== '0) begin
        n_err++;
        $display("FAIL ready_legal cyc=%0d got=%b allowed=%b", cyc, req_ready, mask);
      end
      acc     = req_valid & req_ready;
      pend_wr = |acc;
      for (int i = 0; i < NR; i++) if (acc[i]) pend_byte = req_data[8*i +: 8];
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          void'(q[i].pop_front());
          if (gaps && $urandom_range(3, 0) == 0) gap[i] = $urandom_range(3, 1);
        end else if (gap[i] > 0 && grant_valid && grant_id == IDW'(i)) begin
          gap[i]--;
        end
      end
      drive_reqs();
      empty = 1'b1;
      for (int i = 0; i < NR; i++) if (q[i].size() > 0) empty = 1'b0;
      if (empty && !grant_valid && !uart_busy && b_delay < 0 && !pend_wr) done = 1;
    end
    req_valid = '0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL traffic_timeout got=running exp=idle");
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL byte_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL byte_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_data  = {$urandom};
    uart_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({grant_valid, grant_id, uart_wr, uart_tx_data, req_ready, hi_err} !== '0) begin
      n_err++;
      $display("FAIL reset_state got=%b%b%b%h%b%b exp=all-zero",
               grant_valid, grant_id, uart_wr, uart_tx_data, req_ready, hi_err);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    q[0].push_back(9'h048);
    q[0].push_back(9'h169);
    run_traffic(0, 1, 1, 10, 10, 0);
    // Released pointer now sits past requester 0, so 1 must win next.
    q[0].push_back(9'h111);
    q[1].push_back(9'h122);
    run_traffic(0, 0, HT - 1, 1, 10, 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    q[1].push_back(9'h0A1); q[1].push_back(9'h1B1); q[1].push_back(9'h1C1);
    q[3].push_back(9'h1A3); q[3].push_back(9'h1B3);
    run_traffic(0, 0, HT - 1, 1, 6, 0);
  endtask

  task automatic test_max_burst();
    do_reset();
    q[1].push_back(9'h15A);
    run_traffic(0, 0, 1, 1, 3, 0);
    for (int i = 0; i < 10; i++) q[2].push_back({1'b0, 8'($urandom)});
    q[0].push_back(9'h1C3);
    run_traffic(0, 0, HT - 1, 1, 5, 0);
  endtask

  task automatic test_idle_release();
    logic exp_gv;
    do_reset();
    uart_busy    = 1'b1;
    req_data     = {$urandom};
    req_valid    = 4'b0010;
    @(posedge clk); #1;
    req_valid    = '0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      n_vec++;
      if ({grant_valid, grant_id, req_ready, uart_wr} !== {1'b1, 2'd1, 4'b0000, 1'b0}) begin
        n_err++;
        $display("FAIL busy_stall j=%0d got=%b%b%b%b exp=1_01_0000_0",
                 j, grant_valid, grant_id, req_ready, uart_wr);
      end
    end
    @(posedge clk); #1;
    uart_busy = 1'b0;
    for (int j = 0; j <= IT; j++) begin
      @(negedge clk);
      exp_gv = (j < IT);
      n_vec++;
      if (grant_valid !== exp_gv || req_ready !== (exp_gv ? 4'b0010 : 4'b0000)) begin
        n_err++;
        $display("FAIL idle_release j=%0d got=%b/%b exp=%b/%b", j, grant_valid, req_ready,
                 exp_gv, exp_gv ? 4'b0010 : 4'b0000);
      end
    end
    m_ptr = (1 + 1) % NR;
  endtask

  task automatic test_hi_timeout();
    bit seen;
    do_reset();
    q[2].push_back(9'h031); q[2].push_back(9'h032); q[2].push_back(9'h133);
    run_traffic(1, 0, 0, 1, 1, 0);
    n_vec++;
    if (hi_err !== 1'b1) begin
      n_err++;
      $display("FAIL hi_err_sticky got=%b exp=1", hi_err);
    end
    // Reset while the UART is mid-byte.
    do_reset();
    req_data[7:0] = 8'hA5;
    req_last      = 4'b0001;
    req_valid     = 4'b0001;
    seen = 0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      if (uart_wr) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL wr_wait got=none exp=uart_wr");
    end
    uart_busy = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({grant_valid, grant_id, uart_wr, uart_tx_data, req_ready, hi_err} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_byte got=%b%b%b%h%b%b exp=all-zero",
               grant_valid, grant_id, uart_wr, uart_tx_data, req_ready, hi_err);
    end
    rst_n     = 1'b1;
    uart_busy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_vec++;
      if (uart_wr !== 1'b0 || grant_valid !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset j=%0d got=%b%b exp=00", j, uart_wr, grant_valid);
      end
    end
    m_ptr = 0;
    m_hi  = 1'b0;
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) begin
        n = $urandom_range(7, 0);
        for (int b = 0; b < n; b++) begin
          if (b == n - 1)
            q[i].push_back({($urandom_range(3, 0) != 0), 8'($urandom)});
          else
            q[i].push_back({($urandom_range(2, 0) == 0), 8'($urandom)});
        end
      end
      run_traffic(0, 0, HT - 1, 1, 8, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_idle_release();
    test_hi_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
